// File: rtl/conf_select_4_pkg.sv
// Shared definitions for the conf_select_4 one-to-four request steering block.
// The optional watchdog is enabled with CONF_SELECT_TIMEOUT_EN.
package conf_pkg;

  localparam int CONF_NCH   = 4;
  localparam int CONF_SEL_W = 2;
  localparam int CONF_CNT_W = 16;

  typedef logic [1:0] conf_state_t;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  function automatic logic [CONF_NCH-1:0] conf_onehot(input logic [CONF_SEL_W-1:0] sel);
    conf_onehot = CONF_NCH'(1) << sel;
  endfunction

endpackage

// File: rtl/conf_select_4_if.sv
// Upstream request/acknowledge and downstream per-channel handshake bundle.
// The optional o_err port lives on the top module (CONF_SELECT_TIMEOUT_EN).
interface conf_select_4_if;
  import conf_pkg::*;

  logic                  i_drive;
  logic [CONF_SEL_W-1:0] i_sel;
  logic                  o_free;
  logic [CONF_NCH-1:0]   o_drive;
  logic [CONF_NCH-1:0]   i_free;
  logic                  o_busy;

  modport slave (
    input  i_drive, i_sel, i_free,
    output o_free, o_drive, o_busy
  );

  modport master (
    output i_drive, i_sel, i_free,
    input  o_free, o_drive, o_busy
  );

endinterface

// File: rtl/conf_select_4_watchdog.sv
// WAIT-state watchdog: clears on clr, counts while en, flags the TIMEOUT-th cycle.
// Only instantiated when CONF_SELECT_TIMEOUT_EN is defined.
module conf_watchdog
  import conf_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tc
);

  logic [CONF_CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = cnt_q + CONF_CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // cnt_q holds completed WAIT cycles, so this is the TIMEOUT-th WAIT cycle
  assign tc = en && (cnt_q == CONF_CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/conf_select_4.sv
// One-to-four request steering: each upstream request goes to channel i_sel.
// Define CONF_SELECT_TIMEOUT_EN to add the WAIT watchdog and the o_err port.
//
// state    | meaning
// ST_IDLE  | no transaction, ready for i_drive
// ST_ISSUE | o_drive[sel_q] pulses
// ST_WAIT  | waiting for i_free[sel_q] (or watchdog)
// ST_DONE  | o_free pulses; i_drive here chains the next request
module conf_select_4
  import conf_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  conf_select_4_if.slave    bus
`ifdef CONF_SELECT_TIMEOUT_EN
  ,
  output logic              o_err
`endif
);

  conf_state_t           state_q, state_d;
  logic [CONF_SEL_W-1:0] sel_q, sel_d;
  logic                  free_sel;
  logic                  wd_tc;

  assign free_sel = bus.i_free[sel_q];

`ifdef CONF_SELECT_TIMEOUT_EN
  conf_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
    .clk (clk),
    .rst (rst),
    .clr (state_q == ST_ISSUE),
    .en  (state_q == ST_WAIT),
    .tc  (wd_tc)
  );

  assign o_err = !rst && (state_q == ST_WAIT) && wd_tc && !free_sel;
`else
  logic unused_timeout;
  assign wd_tc          = 1'b0;
  assign unused_timeout = (TIMEOUT != 0);
`endif

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (bus.i_drive) begin
          sel_d   = bus.i_sel;
          state_d = ST_ISSUE;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ISSUE: state_d = ST_WAIT;
      ST_WAIT: begin
        if (free_sel || wd_tc) begin
          state_d = ST_DONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      sel_q   <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
    end
  end

  // Outputs are masked by rst so they are quiet even on the first reset cycle
  assign bus.o_drive = (!rst && state_q == ST_ISSUE) ? conf_onehot(sel_q) : '0;
  assign bus.o_free  = !rst && (state_q == ST_DONE);
  assign bus.o_busy  = !rst && (state_q != ST_IDLE);

endmodule
